multibuf_ring: RTL and testbench

Parametrised N-way ring of frame buffers that generalises the two-buffer ping-pong scheme to NUM_BUFS buffers, a runtime-programmable frame length and a selectable overflow policy. It sits between the sampler/producer and the frame consumer (FFT/DSP stage). It accepts a sample stream, commits whole frames in ring order, and replays them as a ready/valid stream with a last-word marker. There is no buffer-take handshake: reads start automatically. Storage is one inferred simple-dual-port synchronous RAM of NUM_BUFS×BUF_LEN words.

---
 rtl/multibuf_ring.sv | 205 ++++++++++++++++++++
 tb/tb_multibuf_ring.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multibuf_ring.sv
// multibuf_ring: N-way ring of frame buffers carved out of one simple-dual-port RAM.
// Whole frames are committed in ring order and replayed as a ready/valid stream
// with a last-word marker. Reads start automatically once a buffer is READY.
module multibuf_ring #(
    parameter int SAMPLE_W  = 16,
    parameter int BUF_LEN   = 256,
    parameter int NUM_BUFS  = 4,
    parameter int DROP_MODE = 0,
    localparam int AW = $clog2(BUF_LEN),
    localparam int LW = AW + 1,
    localparam int IW = ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1,
    localparam int CW = $clog2(NUM_BUFS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LW-1:0]       cfg_len_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic                wr_flush_i,
    output logic [SAMPLE_W-1:0] rd_data_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic                rd_last_o,
    output logic [IW-1:0]       rd_buf_id_o,
    output logic                buf_done_o,
    output logic [IW-1:0]       buf_done_id_o,
    output logic [CW-1:0]       level_o,
    output logic                overrun_o,
    output logic [15:0]         drop_cnt_o,
    input  logic                clear_err_i
);

    typedef enum logic [1:0] {BUF_EMPTY, BUF_WRITING, BUF_READY, BUF_READING} buf_state_t;

    logic [SAMPLE_W-1:0] mem [NUM_BUFS*BUF_LEN];
    buf_state_t          buf_state [NUM_BUFS];
    logic [LW-1:0]       buf_len [NUM_BUFS];

    logic          alive;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] wr_addr;
    logic          discard;
    logic [LW-1:0] discard_len;

    // The issue pointer runs one word ahead of the output register; it moves on
    // to the next buffer as soon as the last word of the current one is issued.
    logic [IW-1:0] iss_idx;
    logic [AW-1:0] iss_addr;

    logic [LW-1:0] cfg_len_c;
    logic [LW-1:0] eff_len;
    buf_state_t    wr_state;
    buf_state_t    iss_state;
    logic          wr_fire;
    logic          start_drop;
    logic          wr_store;
    logic          wr_last;
    logic          commit;
    logic          disc_last;
    logic          drop_done;
    logic          ovr_set;
    logic          rd_issue;
    logic          iss_last;
    logic          rd_done;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NUM_BUFS - 1)) ? '0 : idx + IW'(1);
    endfunction

    assign cfg_len_c  = (cfg_len_i == '0 || cfg_len_i > LW'(BUF_LEN)) ? LW'(BUF_LEN) : cfg_len_i;
    assign wr_state   = buf_state[wr_idx];
    assign wr_ready_o = alive && ((DROP_MODE != 0) || wr_state == BUF_EMPTY || wr_state == BUF_WRITING);

    // A flush in the same cycle swallows the beat, so it never counts as a write beat.
    assign wr_fire    = wr_valid_i && wr_ready_o && !wr_flush_i;
    assign start_drop = wr_fire && (DROP_MODE != 0) && !discard && wr_addr == '0 && wr_state != BUF_EMPTY;
    assign wr_store   = wr_fire && !discard && !start_drop;
    assign eff_len    = (wr_addr == '0) ? cfg_len_c : buf_len[wr_idx];
    assign wr_last    = ({1'b0, wr_addr} == eff_len - LW'(1));
    assign commit     = wr_store && wr_last;
    assign disc_last  = discard ? ({1'b0, wr_addr} == discard_len - LW'(1)) : (cfg_len_c == LW'(1));
    assign drop_done  = wr_fire && (discard || start_drop) && disc_last;
    assign ovr_set    = drop_done || (alive && wr_valid_i && !wr_ready_o);

    assign iss_state  = buf_state[iss_idx];
    assign rd_issue   = (!rd_valid_o || rd_ready_i) && (iss_state == BUF_READY || iss_state == BUF_READING);
    assign iss_last   = ({1'b0, iss_addr} == buf_len[iss_idx] - LW'(1));
    assign rd_done    = rd_valid_o && rd_ready_i && rd_last_o;

    // Sample storage write port; the RAM contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_store) begin
            mem[{wr_idx, wr_addr}] <= wr_data_i;
        end
    end

    // Buffer ring control: write fill/commit/discard, read issue and completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                buf_state[b] <= BUF_EMPTY;
                buf_len[b]   <= '0;
            end
            wr_idx        <= '0;
            wr_addr       <= '0;
            discard       <= 1'b0;
            discard_len   <= '0;
            iss_idx       <= '0;
            iss_addr      <= '0;
            buf_done_id_o <= '0;
            rd_data_o     <= '0;
            rd_valid_o    <= 1'b0;
            rd_last_o     <= 1'b0;
            rd_buf_id_o   <= '0;
        end else begin
            if (wr_flush_i) begin
                if (!discard && wr_state == BUF_WRITING) begin
                    buf_state[wr_idx] <= BUF_EMPTY;
                end
                discard <= 1'b0;
                wr_addr <= '0;
            end else if (wr_fire) begin
                if (discard || start_drop) begin
                    if (start_drop) begin
                        discard_len <= cfg_len_c;
                    end
                    if (disc_last) begin
                        discard <= 1'b0;
                        wr_addr <= '0;
                    end else begin
                        discard <= 1'b1;
                        wr_addr <= wr_addr + AW'(1);
                    end
                end else begin
                    if (wr_addr == '0) begin
                        buf_len[wr_idx] <= cfg_len_c;
                    end
                    if (wr_last) begin
                        buf_state[wr_idx] <= BUF_READY;
                        wr_addr           <= '0;
                        wr_idx            <= next_idx(wr_idx);
                        buf_done_id_o     <= wr_idx;
                    end else begin
                        buf_state[wr_idx] <= BUF_WRITING;
                        wr_addr           <= wr_addr + AW'(1);
                    end
                end
            end

            if (rd_done) begin
                buf_state[rd_buf_id_o] <= BUF_EMPTY;
            end
            if (rd_issue) begin
                rd_data_o          <= mem[{iss_idx, iss_addr}];
                rd_valid_o         <= 1'b1;
                rd_last_o          <= iss_last;
                rd_buf_id_o        <= iss_idx;
                buf_state[iss_idx] <= BUF_READING;
                if (iss_last) begin
                    iss_addr <= '0;
                    iss_idx  <= next_idx(iss_idx);
                end else begin
                    iss_addr <= iss_addr + AW'(1);
                end
            end else if (rd_ready_i) begin
                rd_valid_o <= 1'b0;
            end
        end
    end

    // Status: commit pulse, fill level, sticky overrun and saturating drop counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alive      <= 1'b0;
            buf_done_o <= 1'b0;
            level_o    <= '0;
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            alive      <= 1'b1;
            buf_done_o <= commit;
            case ({commit, rd_done})
                2'b10:   level_o <= level_o + CW'(1);
                2'b01:   level_o <= level_o - CW'(1);
                default: level_o <= level_o;
            endcase
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clear_err_i) begin
                overrun_o <= 1'b0;
            end
            if (drop_done) begin
                if (clear_err_i) begin
                    drop_cnt_o <= 16'd1;
                end else if (drop_cnt_o != 16'hFFFF) begin
                    drop_cnt_o <= drop_cnt_o + 16'd1;
                end
            end else if (clear_err_i) begin
                drop_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_multibuf_ring.sv
// tb_multibuf_ring: directed checks of multibuf_ring in backpressure and drop mode.
module tb_multibuf_ring;

    localparam int LW = 9;
    localparam int IW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] cfg_len = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_flush = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clear_err = 1'b0;

    logic          b_wr_ready, d_wr_ready;
    logic [15:0]   b_rd_data, d_rd_data;
    logic          b_rd_valid, d_rd_valid;
    logic          b_rd_last, d_rd_last;
    logic [IW-1:0] b_rd_buf_id, d_rd_buf_id;
    logic          b_buf_done, d_buf_done;
    logic [IW-1:0] b_buf_done_id, d_buf_done_id;
    logic [CW-1:0] b_level, d_level;
    logic          b_overrun, d_overrun;
    logic [15:0]   b_drop_cnt, d_drop_cnt;

    bit use_drop = 1'b0;

    wire           o_wr_ready    = use_drop ? d_wr_ready    : b_wr_ready;
    wire [15:0]    o_rd_data     = use_drop ? d_rd_data     : b_rd_data;
    wire           o_rd_valid    = use_drop ? d_rd_valid    : b_rd_valid;
    wire           o_rd_last     = use_drop ? d_rd_last     : b_rd_last;
    wire [IW-1:0]  o_rd_buf_id   = use_drop ? d_rd_buf_id   : b_rd_buf_id;
    wire           o_buf_done    = use_drop ? d_buf_done    : b_buf_done;
    wire [IW-1:0]  o_buf_done_id = use_drop ? d_buf_done_id : b_buf_done_id;
    wire [CW-1:0]  o_level       = use_drop ? d_level       : b_level;
    wire           o_overrun     = use_drop ? d_overrun     : b_overrun;
    wire [15:0]    o_drop_cnt    = use_drop ? d_drop_cnt    : b_drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multibuf_ring #(.SAMPLE_W(16), .BUF_LEN(256), .NUM_BUFS(4), .DROP_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_len_i(cfg_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(b_wr_ready), .wr_flush_i(wr_flush),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .rd_ready_i(rd_ready), .rd_last_o(b_rd_last),
        .rd_buf_id_o(b_rd_buf_id), .buf_done_o(b_buf_done), .buf_done_id_o(b_buf_done_id),
        .level_o(b_level), .overrun_o(b_overrun), .drop_cnt_o(b_drop_cnt), .clear_err_i(clear_err)
    );

    multibuf_ring #(.SAMPLE_W(16), .BUF_LEN(256), .NUM_BUFS(4), .DROP_MODE(1)) dut_drop (
        .clk_i(clk), .rst_i(rst), .cfg_len_i(cfg_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(d_wr_ready), .wr_flush_i(wr_flush),
        .rd_data_o(d_rd_data), .rd_valid_o(d_rd_valid), .rd_ready_i(rd_ready), .rd_last_o(d_rd_last),
        .rd_buf_id_o(d_rd_buf_id), .buf_done_o(d_buf_done), .buf_done_id_o(d_buf_done_id),
        .level_o(d_level), .overrun_o(d_overrun), .drop_cnt_o(d_drop_cnt), .clear_err_i(clear_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One write beat: hold valid until the selected DUT accepts it (bounded).
    task automatic applyStimulus(input logic [15:0] data);
        int waited;
        waited   = 0;
        wr_data  = data;
        wr_valid = 1'b1;
        while (!o_wr_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 300) checkOutput("wr_ready_wait", 32'(o_wr_ready), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic writeFrame(input int base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(16'(base + i));
    endtask

    task automatic readFrame(input int base, input int n, input int id);
        int waited;
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!o_rd_valid && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            checkOutput("rd_valid", 32'(o_rd_valid), 32'd1);
            checkOutput("rd_data", 32'(o_rd_data), 32'(16'(base + i)));
            checkOutput("rd_last", 32'(o_rd_last), (i == n - 1) ? 32'd1 : 32'd0);
            checkOutput("rd_buf_id", 32'(o_rd_buf_id), 32'(id));
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
    endtask

    task automatic pulseReset();
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_flush  = 1'b0;
        rd_ready  = 1'b0;
        clear_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, and wr_ready rising one cycle after release
        $display("[TB] reset state");
        @(posedge clk); #1;
        checkOutput("rst_wr_ready", 32'(b_wr_ready), 32'd0);
        checkOutput("rst_wr_ready_drop", 32'(d_wr_ready), 32'd0);
        checkOutput("rst_level", 32'(b_level), 32'd0);
        checkOutput("rst_rd_valid", 32'(b_rd_valid), 32'd0);
        checkOutput("rst_buf_done", 32'(b_buf_done), 32'd0);
        checkOutput("rst_overrun", 32'(b_overrun), 32'd0);
        checkOutput("rst_drop_cnt", 32'(d_drop_cnt), 32'd0);
        rst = 1'b0;
        checkOutput("rel_wr_ready_pre", 32'(b_wr_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("rel_wr_ready", 32'(b_wr_ready), 32'd1);
        checkOutput("rel_wr_ready_drop", 32'(d_wr_ready), 32'd1);

        // Single 8-word frame with the consumer always ready
        $display("[TB] basic frame");
        cfg_len  = 9'd8;
        rd_ready = 1'b1;
        writeFrame(0, 8);
        checkOutput("basic_buf_done", 32'(o_buf_done), 32'd1);
        checkOutput("basic_done_id", 32'(o_buf_done_id), 32'd0);
        checkOutput("basic_level1", 32'(o_level), 32'd1);
        checkOutput("basic_valid_early", 32'(o_rd_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("basic_valid_lat", 32'(o_rd_valid), 32'd1);
        checkOutput("basic_done_pulse", 32'(o_buf_done), 32'd0);
        readFrame(0, 8, 0);
        checkOutput("basic_level0", 32'(o_level), 32'd0);
        checkOutput("basic_valid_end", 32'(o_rd_valid), 32'd0);

        // Backpressure: fill all four buffers, overrun, clear, free one
        $display("[TB] backpressure fill");
        pulseReset();
        cfg_len = 9'd8;
        for (int f = 0; f < 4; f++) writeFrame(f * 16, 8);
        checkOutput("bp_level4", 32'(o_level), 32'd4);
        checkOutput("bp_wr_ready0", 32'(o_wr_ready), 32'd0);
        checkOutput("bp_overrun0", 32'(o_overrun), 32'd0);
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        checkOutput("bp_overrun1", 32'(o_overrun), 32'd1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        checkOutput("bp_overrun_clr", 32'(o_overrun), 32'd0);
        readFrame(0, 8, 0);
        checkOutput("bp_level3", 32'(o_level), 32'd3);
        checkOutput("bp_wr_ready1", 32'(o_wr_ready), 32'd1);
        checkOutput("bp_next_id", 32'(o_rd_buf_id), 32'd1);
        checkOutput("bp_next_data", 32'(o_rd_data), 32'h10);

        // Drop mode: a frame arriving with no free buffer is discarded whole
        $display("[TB] drop mode");
        use_drop = 1'b1;
        pulseReset();
        cfg_len = 9'd8;
        for (int f = 0; f < 4; f++) writeFrame(f * 16, 8);
        writeFrame(16'hA0, 8);
        checkOutput("drop_cnt1", 32'(o_drop_cnt), 32'd1);
        checkOutput("drop_overrun", 32'(o_overrun), 32'd1);
        checkOutput("drop_level4", 32'(o_level), 32'd4);
        readFrame(0, 8, 0);
        writeFrame(16'h50, 8);
        checkOutput("drop_level_refill", 32'(o_level), 32'd4);
        readFrame(16'h10, 8, 1);
        readFrame(16'h20, 8, 2);
        readFrame(16'h30, 8, 3);
        readFrame(16'h50, 8, 0);
        checkOutput("drop_cnt_hold", 32'(o_drop_cnt), 32'd1);
        checkOutput("drop_level0", 32'(o_level), 32'd0);
        use_drop = 1'b0;

        // Length clamp: 0 and 300 both mean 256 words
        $display("[TB] length clamp");
        pulseReset();
        cfg_len = 9'd0;
        writeFrame(0, 256);
        cfg_len = 9'd300;
        writeFrame(256, 256);
        checkOutput("clamp_level2", 32'(o_level), 32'd2);
        checkOutput("clamp_done_id", 32'(o_buf_done_id), 32'd1);
        readFrame(0, 256, 0);
        readFrame(256, 256, 1);

        // Flush a partial frame, then write a fresh frame into the same buffer
        $display("[TB] flush");
        pulseReset();
        cfg_len = 9'd8;
        writeFrame(16'hE0, 5);
        wr_flush = 1'b1;
        @(posedge clk); #1;
        wr_flush = 1'b0;
        checkOutput("flush_level0", 32'(o_level), 32'd0);
        writeFrame(16'h60, 8);
        checkOutput("flush_level1", 32'(o_level), 32'd1);
        readFrame(16'h60, 8, 0);
        checkOutput("flush_no_extra", 32'(o_rd_valid), 32'd0);

        // Random consumer stalls with back-to-back 4-word frames
        $display("[TB] random stalls");
        pulseReset();
        cfg_len = 9'd4;
        fork
            begin
                for (int f = 0; f < 5; f++) writeFrame(f * 16, 4);
            end
            begin
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 20 && cyc < 3000) begin
                    rd_ready = 1'($urandom_range(0, 1));
                    if (o_rd_valid && rd_ready) begin
                        checkOutput("stall_data", 32'(o_rd_data), 32'((got / 4) * 16 + (got % 4)));
                        checkOutput("stall_buf_id", 32'(o_rd_buf_id), 32'((got / 4) % 4));
                        checkOutput("stall_last", 32'(o_rd_last), ((got % 4) == 3) ? 32'd1 : 32'd0);
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                checkOutput("stall_words", 32'(got), 32'd20);
                rd_ready = 1'b0;
            end
        join
        checkOutput("stall_level0", 32'(o_level), 32'd0);

        // Asynchronous reset in the middle of a frame
        $display("[TB] reset mid-frame");
        cfg_len = 9'd8;
        writeFrame(16'h70, 8);
        writeFrame(16'h80, 3);
        checkOutput("mid_level_pre", 32'(o_level), 32'd1);
        checkOutput("mid_valid_pre", 32'(o_rd_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_level", 32'(o_level), 32'd0);
        checkOutput("mid_rd_valid", 32'(o_rd_valid), 32'd0);
        checkOutput("mid_wr_ready", 32'(o_wr_ready), 32'd0);
        checkOutput("mid_rd_data", 32'(o_rd_data), 32'd0);
        checkOutput("mid_overrun", 32'(o_overrun), 32'd0);
        checkOutput("mid_buf_done_id", 32'(o_buf_done_id), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_wr_ready_rel", 32'(o_wr_ready), 32'd1);
        checkOutput("mid_level_rel", 32'(o_level), 32'd0);
        checkOutput("mid_valid_rel", 32'(o_rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
